// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples rx and presents each good byte with a one-cycle receive_sig pulse.
// Frames whose stop bit is low raise a one-cycle frame_err pulse and leave data_out unchanged.
//
//   state | meaning
//   IDLE  | line idle, waiting for rx_sync low
//   START | counting to mid start bit, rejecting glitches
//   DATA  | sampling DATA_LEN bits, LSB first, one per bit period
//   STOP  | sampling the stop bit, then pulse receive_sig or frame_err
//   BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
  parameter int DATA_LEN     = 8,
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic [DATA_LEN-1:0] data_out,
  output logic                receive_sig,
  output logic                frame_err,
  output logic                rx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    bit_idx, bit_idx_n;
  logic [DATA_LEN-1:0] shift, shift_n;
  logic [DATA_LEN-1:0] data_n;
  logic                recv_n, ferr_n;
  logic                rx_meta, rx_sync;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_out    <= '0;
      receive_sig <= 1'b0;
      frame_err   <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      data_out    <= data_n;
      receive_sig <= recv_n;
      frame_err   <= ferr_n;
      rx_busy     <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data_out;
    recv_n    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (!rx_sync) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_n[bit_idx] = rx_sync;
          cnt_n            = '0;
          if (bit_idx == IDX_LAST) state_n = STOP;
          else                     bit_idx_n = bit_idx + IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a start bit that follows immediately be caught.
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_sync) begin
            data_n  = shift;
            recv_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_sync) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with CLKS_PER_BIT=8, DATA_LEN=8.
// Stimulus pushes expected pulses (kind, data_out, cycle); a negedge monitor pops and compares.
module tb_uart_rx;

  localparam int CPB = 8;
  localparam int DL  = 8;
  localparam int LAT = 79;  // negedge at which rx is driven low -> pulse cycle (2 sync + 77)

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic [DL-1:0] data_out;
  logic          receive_sig;
  logic          frame_err;
  logic          rx_busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    bit       is_err;
    logic [7:0] data;
    int       at;
  } exp_t;

  exp_t sb[$];
  logic [7:0] hold_val = 8'h00;

  uart_rx #(.DATA_LEN(DL), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .receive_sig(receive_sig),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (receive_sig && frame_err) chk("both_pulses", 1, 0);
    if (receive_sig || frame_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, frame_err, receive_sig}, 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", int'(frame_err), int'(e.is_err));
        chk("data_out", int'(data_out), int'(e.data));
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // kind: 0 no pulse expected, 1 good frame, 2 framing error
  task automatic send_frame(input logic [7:0] b, input logic stop, input int kind);
    exp_t e;
    int n;
    n = cyc;
    if (kind == 1) begin
      e.is_err = 1'b0; e.data = b; e.at = n + LAT;
      sb.push_back(e);
      hold_val = b;
    end else if (kind == 2) begin
      e.is_err = 1'b1; e.data = hold_val; e.at = n + LAT;
      sb.push_back(e);
    end
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DL; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_recv", int'(receive_sig), 0);
    chk("reset_ferr", int'(frame_err), 0);
    chk("reset_busy", int'(rx_busy), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single 0xCC frame with rx_busy window.
    n = cyc;
    fork
      send_frame(8'hCC, 1'b1, 1);
      begin
        wait_cyc(n + 2);  chk("busy_before_ts", int'(rx_busy), 0);
        wait_cyc(n + 3);  chk("busy_ts_plus1", int'(rx_busy), 1);
        wait_cyc(n + 78); chk("busy_pre_pulse", int'(rx_busy), 1);
        wait_cyc(n + 79); chk("busy_pulse_cycle", int'(rx_busy), 0);
      end
    join
    repeat (10) @(negedge clk);

    // Back-to-back 0x55 then 0xA3 with no idle gap.
    send_frame(8'h55, 1'b1, 1);
    send_frame(8'hA3, 1'b1, 1);
    repeat (10) @(negedge clk);

    // Two-cycle glitch.
    n = cyc;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    wait_cyc(n + 3); chk("glitch_busy_high", int'(rx_busy), 1);
    wait_cyc(n + 7); chk("glitch_busy_low", int'(rx_busy), 0);
    repeat (10) @(negedge clk);

    // Framing error keeps 0xA3, then 0x3C received.
    send_frame(8'h0F, 1'b0, 2);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("ferr_hold_data", int'(data_out), 8'hA3);
    send_frame(8'h3C, 1'b1, 1);
    repeat (10) @(negedge clk);

    // Line held low for 40 bit times: one frame_err, BREAK until release.
    n = cyc;
    begin
      exp_t e;
      e.is_err = 1'b1; e.data = 8'h3C; e.at = n + LAT;
      sb.push_back(e);
    end
    rx = 1'b0;
    wait_cyc(n + 40 * CPB - 1); chk("break_busy_high", int'(rx_busy), 1);
    wait_cyc(n + 40 * CPB);
    rx = 1'b1;
    wait_cyc(n + 40 * CPB + 5); chk("break_busy_low", int'(rx_busy), 0);
    repeat (10) @(negedge clk);

    // Reset for one cycle during bit 4 of 0xFF, then 0x81.
    n = cyc;
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        wait_cyc(n + 8 + 4 * CPB + 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hold_val = 8'h00;
        chk("mid_reset_data_out", int'(data_out), 0);
        chk("mid_reset_busy", int'(rx_busy), 0);
        chk("mid_reset_recv", int'(receive_sig), 0);
        chk("mid_reset_ferr", int'(frame_err), 0);
      end
    join
    repeat (10) @(negedge clk);
    send_frame(8'h81, 1'b1, 1);
    repeat (20) @(negedge clk);
    chk("final_data_out", int'(data_out), 8'h81);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
